// File: rtl/life_gen_sequencer_if.sv
// Bus bundle between the Game of Life generation sequencer and its neighbours:
// the board row RAM, the super_sipo 3-row window and the next-gen row buffer.
//
// Parameters
//   COLS    board width in cells (super_sipo word width)
//   ADDR_W  row address width
//
// Signals (named from the sequencer's point of view)
//   start_i      request one generation
//   rd_en_o      board RAM read strobe, data valid one cycle later
//   rd_addr_o    board RAM row address
//   rd_data_i    board RAM row data, bit c = column c
//   sipo_en_o    super_sipo shift enable
//   sipo_d_o     super_sipo data in
//   window_i     super_sipo 3-row window: [COLS-1:0]=row r-1, middle=row r, top=row r+1
//   wr_en_o      next-gen buffer write strobe
//   wr_addr_o    next-gen row address
//   wr_data_o    next-gen row data
//   busy_o       generation in progress
//   done_o       one-cycle pulse after the last row write
//   gen_count_o  completed generations
//
// Modports
//   master  the sequencer
//   slave   the surrounding environment (RAM, super_sipo, buffer, top level)
interface life_gen_sequencer_if #(
    parameter int COLS   = 20,
    parameter int ADDR_W = 4
);
    logic                start_i;
    logic                rd_en_o;
    logic [ADDR_W-1:0]   rd_addr_o;
    logic [COLS-1:0]     rd_data_i;
    logic                sipo_en_o;
    logic [COLS-1:0]     sipo_d_o;
    logic [3*COLS-1:0]   window_i;
    logic                wr_en_o;
    logic [ADDR_W-1:0]   wr_addr_o;
    logic [COLS-1:0]     wr_data_o;
    logic                busy_o;
    logic                done_o;
    logic [15:0]         gen_count_o;

    modport master (
        input  start_i, rd_data_i, window_i,
        output rd_en_o, rd_addr_o, sipo_en_o, sipo_d_o,
               wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, gen_count_o
    );

    modport slave (
        output start_i, rd_data_i, window_i,
        input  rd_en_o, rd_addr_o, sipo_en_o, sipo_d_o,
               wr_en_o, wr_addr_o, wr_data_o, busy_o, done_o, gen_count_o
    );
endinterface

// File: rtl/life_gen_sequencer.sv
// Game of Life generation controller. Reads the current board row by row
// from a synchronous row RAM, streams the rows into super_sipo (3-row window)
// and, for each row, evaluates the next state of the window's middle row and
// writes it to the next-gen buffer. The buffer swap lives at top level.
//
// Configuration macro: LIFE_WRAP_EN
//   defined   - toroidal board: rows and columns wrap; the top/bottom boundary
//               loads are real RAM reads of row ROWS-1 / row 0.
//   undefined - cells outside the board are dead; boundary loads are zero
//               words pushed into super_sipo without a RAM read.
//
// Ports
//   clk_50MHz_i  in   system clock, rising edge
//   rst_sync_i   in   synchronous reset, active-high; aborts a generation at once
//   bus          life_gen_sequencer_if.master (see interface file)
//
// State  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for start_i
// RD     | RAM read of the row selected by ld_idx
// LD     | push RAM data (or a dead zero row) into super_sipo
// EVAL   | window stable; register next-gen row and its address
// WR     | next-gen buffer write strobe
// DONE   | done pulse, generation counter increment
module life_gen_sequencer #(
    parameter int ROWS   = 16,
    parameter int COLS   = 20,
    parameter int ADDR_W = 4
) (
    input  logic                 clk_50MHz_i,
    input  logic                 rst_sync_i,
    life_gen_sequencer_if.master bus
);

`ifdef LIFE_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    // ld_idx walks the load sequence: 0 = top boundary, k = row k-1,
    // ROWS+1 = bottom boundary. It needs one bit more than a row address.
    localparam int IDX_W = ADDR_W + 1;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_LD   = 3'd2;
    localparam logic [2:0] S_EVAL = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_DONE = 3'd5;

    localparam logic [IDX_W-1:0]  IDX_BOT  = IDX_W'(ROWS + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROWS - 1);

    logic [2:0]        state;
    logic [IDX_W-1:0]  ld_idx;
    logic [IDX_W-1:0]  next_idx;
    logic [ADDR_W-1:0] wr_addr;
    logic [COLS-1:0]   wr_data;
    logic [15:0]       gen_count;

    logic              boundary;
    logic              dead_load;
    logic              next_dead;
    logic [ADDR_W-1:0] load_row;

    logic [COLS-1:0]   row_bot;
    logic [COLS-1:0]   row_mid;
    logic [COLS-1:0]   row_top;
    logic [COLS+1:0]   pad_bot;
    logic [COLS+1:0]   pad_mid;
    logic [COLS+1:0]   pad_top;
    logic [COLS-1:0]   next_row;

    // ------------------------------------------------------------------
    // Load sequencing helpers
    // ------------------------------------------------------------------
    assign next_idx  = ld_idx + 1'b1;
    assign boundary  = (ld_idx == '0) || (ld_idx == IDX_BOT);
    assign dead_load = !WRAP && boundary;
    assign next_dead = !WRAP && (next_idx == IDX_BOT);

    // Boundary loads map onto the opposite edge of the board (only read
    // from RAM when wrapping); interior loads fetch row ld_idx-1.
    always_comb begin
        load_row = '0;
        if (ld_idx == '0) begin
            load_row = LAST_ROW;
        end else if (ld_idx != IDX_BOT) begin
            load_row = ADDR_W'(ld_idx - 1'b1);
        end
    end

    // ------------------------------------------------------------------
    // Next-state evaluation of the window's middle row
    // ------------------------------------------------------------------
    assign row_bot = bus.window_i[COLS-1:0];
    assign row_mid = bus.window_i[2*COLS-1:COLS];
    assign row_top = bus.window_i[3*COLS-1:2*COLS];

    // Padded rows: pad[0] is column -1, pad[c+1] is column c, pad[COLS+1]
    // is column COLS. Edge columns are dead or wrapped.
    assign pad_bot = WRAP ? {row_bot[0], row_bot, row_bot[COLS-1]} : {1'b0, row_bot, 1'b0};
    assign pad_mid = WRAP ? {row_mid[0], row_mid, row_mid[COLS-1]} : {1'b0, row_mid, 1'b0};
    assign pad_top = WRAP ? {row_top[0], row_top, row_top[COLS-1]} : {1'b0, row_top, 1'b0};

    for (genvar c = 0; c < COLS; c++) begin : g_cell
        logic [3:0] n;
        assign n = 4'(pad_bot[c]) + 4'(pad_bot[c+1]) + 4'(pad_bot[c+2])
                 + 4'(pad_mid[c])                    + 4'(pad_mid[c+2])
                 + 4'(pad_top[c]) + 4'(pad_top[c+1]) + 4'(pad_top[c+2]);
        assign next_row[c] = (n == 4'd3) | (pad_mid[c+1] & (n == 4'd2));
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_50MHz_i) begin
        if (rst_sync_i) begin
            state     <= S_IDLE;
            ld_idx    <= '0;
            wr_addr   <= '0;
            wr_data   <= '0;
            gen_count <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        ld_idx <= '0;
                        state  <= WRAP ? S_RD : S_LD;
                    end
                end
                S_RD: begin
                    state <= S_LD;
                end
                S_LD: begin
                    // Loads 0 and 1 only prime the window; from load 2 on
                    // every load completes a window to evaluate.
                    if (ld_idx < IDX_W'(2)) begin
                        ld_idx <= next_idx;
                        state  <= S_RD;
                    end else begin
                        state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    wr_data <= next_row;
                    wr_addr <= ADDR_W'(ld_idx - IDX_W'(2));
                    state   <= S_WR;
                end
                S_WR: begin
                    if (wr_addr == LAST_ROW) begin
                        state <= S_DONE;
                    end else begin
                        ld_idx <= next_idx;
                        state  <= next_dead ? S_LD : S_RD;
                    end
                end
                S_DONE: begin
                    gen_count <= gen_count + 16'd1;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.rd_en_o     = (state == S_RD);
    assign bus.rd_addr_o   = (state == S_RD) ? load_row : '0;
    assign bus.sipo_en_o   = (state == S_LD);
    assign bus.sipo_d_o    = ((state == S_LD) && !dead_load) ? bus.rd_data_i : '0;
    assign bus.wr_en_o     = (state == S_WR);
    assign bus.wr_addr_o   = wr_addr;
    assign bus.wr_data_o   = wr_data;
    assign bus.busy_o      = (state == S_RD) || (state == S_LD) ||
                             (state == S_EVAL) || (state == S_WR);
    assign bus.done_o      = (state == S_DONE);
    assign bus.gen_count_o = gen_count;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Directed bench for life_gen_sequencer on an 8x20 board. Models the board
// RAM, super_sipo and the next-gen buffer; expected boards are hand-derived.
module tb_life_gen_sequencer;

    localparam int ROWS    = 8;
    localparam int COLS    = 20;
    localparam int AW      = 3;
    localparam int RUN_CYC = 60;

`ifdef LIFE_WRAP_EN
    localparam int LAST_BUSY = 36;
`else
    localparam int LAST_BUSY = 34;
`endif
    localparam int DONE_CYC = LAST_BUSY + 1;

    logic clk = 1'b0;
    logic rst;
    logic model_clr;

    always #10 clk = ~clk;

    life_gen_sequencer_if #(.COLS(COLS), .ADDR_W(AW)) bus ();

    life_gen_sequencer #(.ROWS(ROWS), .COLS(COLS), .ADDR_W(AW)) dut (
        .clk_50MHz_i (clk),
        .rst_sync_i  (rst),
        .bus         (bus)
    );

    logic [COLS-1:0] board [ROWS];
    logic [COLS-1:0] nxt   [ROWS];
    logic [COLS-1:0] expb  [ROWS];

    // Board RAM: one-cycle read latency.
    always @(posedge clk) begin
        if (model_clr)        bus.rd_data_i <= '0;
        else if (bus.rd_en_o) bus.rd_data_i <= board[bus.rd_addr_o];
    end

    // super_sipo: newest word enters the top slot, oldest drops out the bottom.
    always @(posedge clk) begin
        if (model_clr)          bus.window_i <= '0;
        else if (bus.sipo_en_o) bus.window_i <= {bus.sipo_d_o, bus.window_i[3*COLS-1:COLS]};
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int          n_wr, n_done, first_busy, last_busy, done_cyc, busy_cnt, wr_after_rst;
    bit          order_ok;
    logic [15:0] gen_at_done, gen_after_done, snap_gen;
    logic [10:0] snap_ctl;
    logic [39:0] snap_data;
    logic [15:0] exp_gen;

    // Starts a generation (start high during cycle 0) and observes cycles
    // 1..RUN_CYC. Optional extra start pulse and reset pulse at given cycles.
    task automatic run_gen(input int extra_start_at, input int rst_at);
        for (int r = 0; r < ROWS; r++) nxt[r] = '1;
        n_wr = 0; n_done = 0; first_busy = -1; last_busy = -1; done_cyc = -1;
        busy_cnt = 0; wr_after_rst = 0; order_ok = 1'b1;
        gen_at_done = '1; gen_after_done = '1;
        snap_ctl = '1; snap_data = '1; snap_gen = '1;
        bus.start_i = 1'b1;
        @(posedge clk); #1;
        bus.start_i = 1'b0;
        for (int cyc = 1; cyc <= RUN_CYC; cyc++) begin
            if (bus.busy_o) begin
                if (first_busy < 0) first_busy = cyc;
                last_busy = cyc;
                busy_cnt++;
            end
            if (bus.done_o) begin
                n_done++;
                done_cyc    = cyc;
                gen_at_done = bus.gen_count_o;
            end
            if (done_cyc > 0 && cyc == done_cyc + 1) gen_after_done = bus.gen_count_o;
            if (bus.wr_en_o) begin
                if (bus.wr_addr_o != AW'(n_wr)) order_ok = 1'b0;
                nxt[bus.wr_addr_o] = bus.wr_data_o;
                n_wr++;
                if (rst_at >= 0 && cyc > rst_at) wr_after_rst++;
            end
            if (rst_at >= 0 && cyc == rst_at + 1) begin
                snap_ctl  = {bus.rd_en_o, bus.rd_addr_o, bus.sipo_en_o, bus.wr_en_o,
                             bus.wr_addr_o, bus.busy_o, bus.done_o};
                snap_data = {bus.sipo_d_o, bus.wr_data_o};
                snap_gen  = bus.gen_count_o;
            end
            bus.start_i = (cyc == extra_start_at);
            rst         = (cyc == rst_at);
            @(posedge clk); #1;
        end
        bus.start_i = 1'b0;
        rst         = 1'b0;
    endtask

    task automatic set_board(input logic [COLS-1:0] r0, r1, r2, r3, r4, r5, r6, r7);
        board[0] = r0; board[1] = r1; board[2] = r2; board[3] = r3;
        board[4] = r4; board[5] = r5; board[6] = r6; board[7] = r7;
    endtask

    task automatic set_exp(input logic [COLS-1:0] r0, r1, r2, r3, r4, r5, r6, r7);
        expb[0] = r0; expb[1] = r1; expb[2] = r2; expb[3] = r3;
        expb[4] = r4; expb[5] = r5; expb[6] = r6; expb[7] = r7;
    endtask

    task automatic check_board(input string tag);
        for (int r = 0; r < ROWS; r++)
            check($sformatf("%s_row%0d", tag, r), 64'(nxt[r]), 64'(expb[r]));
    endtask

    task automatic check_gen_ok(input string tag);
        exp_gen = exp_gen + 16'd1;
        check({tag, "_writes"}, 64'(n_wr), 64'(ROWS));
        check({tag, "_addr_order"}, 64'(order_ok), 64'd1);
        check({tag, "_done_pulses"}, 64'(n_done), 64'd1);
        check({tag, "_gen_count"}, 64'(bus.gen_count_o), 64'(exp_gen));
    endtask

    initial begin
        rst = 1'b1;
        model_clr = 1'b1;
        bus.start_i = 1'b0;
        set_board('0, '0, '0, '0, '0, '0, '0, '0);
        exp_gen = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctl", 64'({bus.rd_en_o, bus.rd_addr_o, bus.sipo_en_o, bus.wr_en_o,
                                bus.wr_addr_o, bus.busy_o, bus.done_o}), 64'd0);
        check("reset_data", 64'({bus.sipo_d_o, bus.wr_data_o}), 64'd0);
        check("reset_gen", 64'(bus.gen_count_o), 64'd0);
        rst = 1'b0;
        model_clr = 1'b0;
        @(posedge clk); #1;

        // Blinker: row 4 cols 5..7 -> column 6 on rows 3,4,5.
        set_board('0, '0, '0, '0, 20'h000E0, '0, '0, '0);
        set_exp('0, '0, '0, 20'h00040, 20'h00040, 20'h00040, '0, '0);
        run_gen(-1, -1);
        check_board("blinker");
        check_gen_ok("blinker");
        // Timing of the same run.
        check("t_first_busy", 64'(first_busy), 64'd1);
        check("t_last_busy", 64'(last_busy), 64'(LAST_BUSY));
        check("t_busy_cycles", 64'(busy_cnt), 64'(LAST_BUSY));
        check("t_done_cycle", 64'(done_cyc), 64'(DONE_CYC));
        check("t_gen_at_done", 64'(gen_at_done), 64'd0);
        check("t_gen_after_done", 64'(gen_after_done), 64'd1);

        // Block still life at rows 2..3, cols 10..11.
        set_board('0, '0, 20'h00C00, 20'h00C00, '0, '0, '0, '0);
        set_exp('0, '0, 20'h00C00, 20'h00C00, '0, '0, '0, '0);
        run_gen(-1, -1);
        check_board("block");
        check_gen_ok("block");

        // Column-0 vertical line on rows 7,0,1.
        set_board(20'h00001, 20'h00001, '0, '0, '0, '0, '0, 20'h00001);
`ifdef LIFE_WRAP_EN
        set_exp(20'h80003, '0, '0, '0, '0, '0, '0, '0);
`else
        // Rows 0,1 form a two-cell domino and row 7 is isolated: all die.
        set_exp('0, '0, '0, '0, '0, '0, '0, '0);
`endif
        run_gen(-1, -1);
        check_board("edge_col0");
        check_gen_ok("edge_col0");

        // Lone cell at row 3 col 19 dies.
        set_board('0, '0, '0, 20'h80000, '0, '0, '0, '0);
        set_exp('0, '0, '0, '0, '0, '0, '0, '0);
        run_gen(-1, -1);
        check_board("lone");
        check_gen_ok("lone");

        // Start pulse mid-generation is ignored.
        set_board('0, '0, '0, '0, 20'h000E0, '0, '0, '0);
        set_exp('0, '0, '0, 20'h00040, 20'h00040, 20'h00040, '0, '0);
        run_gen(5, -1);
        check_board("restart_busy");
        check_gen_ok("restart_busy");
        check("restart_busy_cycles", 64'(busy_cnt), 64'(LAST_BUSY));

        // Start pulse during DONE is ignored too.
        run_gen(DONE_CYC, -1);
        check_gen_ok("restart_done");
        check("restart_done_busy_cycles", 64'(busy_cnt), 64'(LAST_BUSY));

        // Reset at cycle 10 aborts the generation.
        run_gen(-1, 10);
        exp_gen = '0;
        check("rst_ctl", 64'(snap_ctl), 64'd0);
        check("rst_data", 64'(snap_data), 64'd0);
        check("rst_gen", 64'(snap_gen), 64'd0);
        check("rst_writes_after", 64'(wr_after_rst), 64'd0);
        check("rst_done_pulses", 64'(n_done), 64'd0);
        check("rst_last_busy", 64'(last_busy), 64'd10);

        // Fresh generation after the abort.
        run_gen(-1, -1);
        check_board("post_rst");
        check_gen_ok("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
